// File: rtl/text_console.sv
// text_console: character-stream to text-RAM writer with cursor tracking,
// line wrap, hardware scroll and line/screen clearing.
// Optional feature macro: TEXT_CONSOLE_TAB_EN (0x09 jumps to next tab stop).
module text_console #(
  parameter int ADDRW      = 14,
  parameter int WORD       = 32,
  parameter int CIDXW      = 4,
  parameter int TRAM_DEPTH = 16384
) (
  input  logic              clk_sys,
  input  logic              rst_sys_n,
  input  logic [ADDRW-1:0]  text_hres,
  input  logic [ADDRW-1:0]  text_vres,
  input  logic [CIDXW-1:0]  colr_fg,
  input  logic [CIDXW-1:0]  colr_bg,
  input  logic              ch_valid,
  output logic              ch_ready,
  input  logic [20:0]       ch_data,
  output logic              tram_we,
  output logic [ADDRW-1:0]  tram_addr_w,
  output logic [WORD-1:0]   tram_din,
  output logic [ADDRW-1:0]  scroll_offs,
  output logic [ADDRW-1:0]  cur_x,
  output logic [ADDRW-1:0]  cur_y
);

  localparam logic [ADDRW:0]   DEPTH = (ADDRW+1)'(TRAM_DEPTH);
  localparam logic [ADDRW-1:0] A_ONE = ADDRW'(1);
  localparam logic [ADDRW:0]   W_ONE = (ADDRW+1)'(1);

  localparam logic [20:0] UCP_BS    = 21'h08;
  localparam logic [20:0] UCP_LF    = 21'h0A;
  localparam logic [20:0] UCP_FF    = 21'h0C;
  localparam logic [20:0] UCP_CR    = 21'h0D;
  localparam logic [20:0] UCP_SPACE = 21'h20;
`ifdef TEXT_CONSOLE_TAB_EN
  localparam logic [20:0] UCP_HT    = 21'h09;
`endif

  typedef enum logic [1:0] {
    IDLE,
    CLR_LINE,
    CLR_SCREEN
  } state_t;

  state_t              r_state, w_state_n;
  logic                r_we, w_we_n;
  logic [ADDRW-1:0]    r_addr, w_addr_n;
  logic [WORD-1:0]     r_din, w_din_n;
  logic [ADDRW-1:0]    r_scroll, w_scroll_n;
  logic [ADDRW-1:0]    r_cur_x, w_cur_x_n;
  logic [ADDRW-1:0]    r_cur_y, w_cur_y_n;
  logic [ADDRW-1:0]    r_line, w_line_n;
  logic [ADDRW-1:0]    r_clr_addr, w_clr_addr_n;
  logic [ADDRW-1:0]    r_clr_col, w_clr_col_n;
  logic [ADDRW-1:0]    r_clr_row, w_clr_row_n;
  logic                r_clr_done, w_clr_done_n;

  logic                w_accept;
  logic                w_nl;
  logic                w_printable;
  logic                w_last_col;
  logic                w_last_row;
  logic [ADDRW-1:0]    w_cur_addr;
  logic [ADDRW-1:0]    w_line_nx;
  logic [ADDRW-1:0]    w_scroll_nx;
  logic [ADDRW-1:0]    w_clr_addr_inc;
`ifdef TEXT_CONSOLE_TAB_EN
  logic [ADDRW:0]      w_tab_nx;
  logic [ADDRW-1:0]    w_hres_m1;
`endif

  // Modular add of two in-range addresses; a single conditional subtract suffices.
  function automatic logic [ADDRW-1:0] add_mod(input logic [ADDRW-1:0] a,
                                                input logic [ADDRW-1:0] b);
    logic [ADDRW:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= DEPTH) s = s - DEPTH;
    return s[ADDRW-1:0];
  endfunction

  function automatic logic [ADDRW-1:0] inc_mod(input logic [ADDRW-1:0] a);
    if ({1'b0, a} == DEPTH - W_ONE) return '0;
    return a + A_ONE;
  endfunction

  function automatic logic [WORD-1:0] pack(input logic [20:0]      ucp,
                                           input logic [CIDXW-1:0] fg,
                                           input logic [CIDXW-1:0] bg);
    logic [WORD-1:0] d;
    d = '0;
    d[20:0] = ucp;
    d[WORD-1 -: CIDXW] = bg;
    d[WORD-CIDXW-1 -: CIDXW] = fg;
    return d;
  endfunction

  assign ch_ready       = (r_state == IDLE);
  assign w_accept       = ch_valid && ch_ready;
  assign w_cur_addr     = add_mod(r_line, r_cur_x);
  assign w_line_nx      = add_mod(r_line, text_hres);
  assign w_scroll_nx    = add_mod(r_scroll, text_hres);
  assign w_clr_addr_inc = inc_mod(r_clr_addr);
  assign w_last_col     = (r_clr_col == text_hres - A_ONE);
  assign w_last_row     = (r_state == CLR_LINE) || (r_clr_row == text_vres - A_ONE);
`ifdef TEXT_CONSOLE_TAB_EN
  assign w_tab_nx       = {1'b0, r_cur_x | ADDRW'(7)} + W_ONE;
  assign w_hres_m1      = text_hres - A_ONE;
`endif

  assign w_printable = !((ch_data == UCP_LF) || (ch_data == UCP_CR) ||
                         (ch_data == UCP_BS) || (ch_data == UCP_FF)
`ifdef TEXT_CONSOLE_TAB_EN
                         || (ch_data == UCP_HT)
`endif
                        );

  assign tram_we     = r_we;
  assign tram_addr_w = r_addr;
  assign tram_din    = r_din;
  assign scroll_offs = r_scroll;
  assign cur_x       = r_cur_x;
  assign cur_y       = r_cur_y;

  // Next-state and datapath: char handling in IDLE, one clear write per cycle otherwise.
  // The clear sequencer runs one extra cycle after its last write (r_clr_done)
  // so that ch_ready rises the cycle after that write is visible.
  always_comb begin
    w_state_n    = r_state;
    w_we_n       = 1'b0;
    w_addr_n     = r_addr;
    w_din_n      = r_din;
    w_scroll_n   = r_scroll;
    w_cur_x_n    = r_cur_x;
    w_cur_y_n    = r_cur_y;
    w_line_n     = r_line;
    w_clr_addr_n = r_clr_addr;
    w_clr_col_n  = r_clr_col;
    w_clr_row_n  = r_clr_row;
    w_clr_done_n = r_clr_done;
    w_nl         = 1'b0;

    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_printable) begin
            w_we_n   = 1'b1;
            w_addr_n = w_cur_addr;
            w_din_n  = pack(ch_data, colr_fg, colr_bg);
            if (({1'b0, r_cur_x} + W_ONE) == {1'b0, text_hres}) w_nl = 1'b1;
            else w_cur_x_n = r_cur_x + A_ONE;
          end else if (ch_data == UCP_LF) begin
            w_nl = 1'b1;
          end else if (ch_data == UCP_CR) begin
            w_cur_x_n = '0;
          end else if (ch_data == UCP_BS) begin
            if (r_cur_x != '0) w_cur_x_n = r_cur_x - A_ONE;
          end else if (ch_data == UCP_FF) begin
            w_state_n    = CLR_SCREEN;
            w_scroll_n   = '0;
            w_cur_x_n    = '0;
            w_cur_y_n    = '0;
            w_line_n     = '0;
            w_clr_addr_n = '0;
            w_clr_col_n  = '0;
            w_clr_row_n  = '0;
            w_clr_done_n = 1'b0;
          end
`ifdef TEXT_CONSOLE_TAB_EN
          else begin
            if (w_tab_nx > {1'b0, w_hres_m1}) w_cur_x_n = w_hres_m1;
            else w_cur_x_n = w_tab_nx[ADDRW-1:0];
          end
`endif

          if (w_nl) begin
            w_cur_x_n = '0;
            w_line_n  = w_line_nx;
            if (r_cur_y < text_vres - A_ONE) begin
              w_cur_y_n = r_cur_y + A_ONE;
            end else begin
              w_scroll_n   = w_scroll_nx;
              w_state_n    = CLR_LINE;
              w_clr_addr_n = w_line_nx;
              w_clr_col_n  = '0;
              w_clr_row_n  = '0;
              w_clr_done_n = 1'b0;
            end
          end
        end
      end

      CLR_LINE, CLR_SCREEN: begin
        if (!r_clr_done) begin
          w_we_n       = 1'b1;
          w_addr_n     = r_clr_addr;
          w_din_n      = pack(UCP_SPACE, colr_fg, colr_bg);
          w_clr_addr_n = w_clr_addr_inc;
          if (w_last_col) begin
            w_clr_col_n = '0;
            if (w_last_row) w_clr_done_n = 1'b1;
            else w_clr_row_n = r_clr_row + A_ONE;
          end else begin
            w_clr_col_n = r_clr_col + A_ONE;
          end
        end else begin
          w_state_n    = IDLE;
          w_clr_done_n = 1'b0;
        end
      end

      default: w_state_n = CLR_SCREEN;
    endcase
  end

  // State and datapath registers; reset aborts any operation and arms a full clear.
  always_ff @(posedge clk_sys) begin
    if (!rst_sys_n) begin
      r_state    <= CLR_SCREEN;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_din      <= '0;
      r_scroll   <= '0;
      r_cur_x    <= '0;
      r_cur_y    <= '0;
      r_line     <= '0;
      r_clr_addr <= '0;
      r_clr_col  <= '0;
      r_clr_row  <= '0;
      r_clr_done <= 1'b0;
    end else begin
      r_state    <= w_state_n;
      r_we       <= w_we_n;
      r_addr     <= w_addr_n;
      r_din      <= w_din_n;
      r_scroll   <= w_scroll_n;
      r_cur_x    <= w_cur_x_n;
      r_cur_y    <= w_cur_y_n;
      r_line     <= w_line_n;
      r_clr_addr <= w_clr_addr_n;
      r_clr_col  <= w_clr_col_n;
      r_clr_row  <= w_clr_row_n;
      r_clr_done <= w_clr_done_n;
    end
  end

endmodule

// File: tb/tb_text_console.sv
// Directed bench for text_console: 4x3 chars in a 16-entry tram.
module tb_text_console;

  localparam int ADDRW = 14;
  localparam int WORD  = 32;
  localparam int CIDXW = 4;
  localparam int DEPTH = 16;

  logic              clk_sys = 1'b0;
  logic              rst_sys_n;
  logic [ADDRW-1:0]  text_hres, text_vres;
  logic [CIDXW-1:0]  colr_fg, colr_bg;
  logic              ch_valid;
  logic              ch_ready;
  logic [20:0]       ch_data;
  logic              tram_we;
  logic [ADDRW-1:0]  tram_addr_w;
  logic [WORD-1:0]   tram_din;
  logic [ADDRW-1:0]  scroll_offs, cur_x, cur_y;

  text_console #(
    .ADDRW(ADDRW), .WORD(WORD), .CIDXW(CIDXW), .TRAM_DEPTH(DEPTH)
  ) dut (
    .clk_sys(clk_sys), .rst_sys_n(rst_sys_n),
    .text_hres(text_hres), .text_vres(text_vres),
    .colr_fg(colr_fg), .colr_bg(colr_bg),
    .ch_valid(ch_valid), .ch_ready(ch_ready), .ch_data(ch_data),
    .tram_we(tram_we), .tram_addr_w(tram_addr_w), .tram_din(tram_din),
    .scroll_offs(scroll_offs), .cur_x(cur_x), .cur_y(cur_y)
  );

  always #5 clk_sys = ~clk_sys;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  int          q_addr[$];
  logic [31:0] q_din[$];
  int          q_cyc[$];

  // Write log, sampled just after each rising edge.
  always @(posedge clk_sys) begin
    #1;
    cyc = cyc + 1;
    if (tram_we === 1'b1) begin
      q_addr.push_back(int'(tram_addr_w));
      q_din.push_back(tram_din);
      q_cyc.push_back(cyc);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] mkdin(input logic [20:0] ucp, input logic [3:0] fg,
                                        input logic [3:0] bg);
    return {bg, fg, 3'b000, ucp};
  endfunction

  task automatic log_clear();
    q_addr.delete();
    q_din.delete();
    q_cyc.delete();
  endtask

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic send(input logic [20:0] c);
    int n;
    n = 0;
    while (!ch_ready && n < 200) begin
      @(negedge clk_sys);
      n++;
    end
    if (!ch_ready) chk("send_ready_timeout", 32'(ch_ready), 32'd1);
    ch_valid = 1'b1;
    ch_data  = c;
    @(negedge clk_sys);
    ch_valid = 1'b0;
  endtask

  // Waits for ch_ready and checks the logged clear writes.
  task automatic expect_clear(input string nm, input int first, input int n);
    int k;
    int rcyc;
    k = 0;
    while (!ch_ready && k < 200) begin
      @(negedge clk_sys);
      k++;
    end
    rcyc = cyc;
    chk({nm, "_ready"}, 32'(ch_ready), 32'd1);
    chk({nm, "_count"}, 32'(q_addr.size()), 32'(n));
    if (q_addr.size() == n && n > 0) begin
      for (int i = 0; i < n; i++) begin
        chk({nm, "_addr"}, 32'(q_addr[i]), 32'((first + i) % DEPTH));
        chk({nm, "_din"}, q_din[i], mkdin(21'h20, colr_fg, colr_bg));
      end
      chk({nm, "_ready_lat"}, 32'(rcyc), 32'(q_cyc[n-1] + 1));
    end
  endtask

  typedef struct {
    logic [20:0] ch;
    logic [3:0]  fg;
    logic [3:0]  bg;
    logic        we;
    int          addr;
    int          cx;
    int          cy;
    int          sc;
  } vec_t;

  vec_t tv[12];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tv[0]  = '{21'h41, 4'd1, 4'd0, 1'b1, 0, 1, 0, 0};
    tv[1]  = '{21'h42, 4'd2, 4'd3, 1'b1, 1, 2, 0, 0};
    tv[2]  = '{21'h43, 4'd2, 4'd3, 1'b1, 2, 3, 0, 0};
    tv[3]  = '{21'h44, 4'd5, 4'd6, 1'b1, 3, 0, 1, 0};
    tv[4]  = '{21'h45, 4'd1, 4'd0, 1'b1, 4, 1, 1, 0};
`ifdef TEXT_CONSOLE_TAB_EN
    tv[5]  = '{21'h09, 4'd1, 4'd0, 1'b0, 0, 3, 1, 0};
`else
    tv[5]  = '{21'h09, 4'd1, 4'd0, 1'b1, 5, 2, 1, 0};
`endif
    tv[6]  = '{21'h0D, 4'd1, 4'd0, 1'b0, 0, 0, 1, 0};
    tv[7]  = '{21'h08, 4'd1, 4'd0, 1'b0, 0, 0, 1, 0};
    tv[8]  = '{21'h0A, 4'd1, 4'd0, 1'b0, 0, 0, 2, 0};
    tv[9]  = '{21'h5A, 4'd7, 4'd8, 1'b1, 8, 1, 2, 0};
    tv[10] = '{21'h08, 4'd1, 4'd0, 1'b0, 0, 0, 2, 0};
    tv[11] = '{21'h08, 4'd1, 4'd0, 1'b0, 0, 0, 2, 0};

    rst_sys_n = 1'b0;
    text_hres = 14'd4;
    text_vres = 14'd3;
    colr_fg   = 4'd1;
    colr_bg   = 4'd0;
    ch_valid  = 1'b0;
    ch_data   = '0;

    // Reset state
    repeat (3) @(negedge clk_sys);
    chk("rst_we", 32'(tram_we), 32'd0);
    chk("rst_addr", 32'(tram_addr_w), 32'd0);
    chk("rst_din", tram_din, 32'd0);
    chk("rst_ready", 32'(ch_ready), 32'd0);
    chk("rst_scroll", 32'(scroll_offs), 32'd0);
    chk("rst_cx", 32'(cur_x), 32'd0);
    chk("rst_cy", 32'(cur_y), 32'd0);

    // Release: full-screen clear of 12 cells
    log_clear();
    rst_sys_n = 1'b1;
    expect_clear("init_clr", 0, 12);

    // Table of single characters
    for (int i = 0; i < 12; i++) begin
      colr_fg = tv[i].fg;
      colr_bg = tv[i].bg;
      send(tv[i].ch);
      chk($sformatf("v%0d_we", i), 32'(tram_we), 32'(tv[i].we));
      if (tv[i].we) begin
        chk($sformatf("v%0d_addr", i), 32'(tram_addr_w), 32'(tv[i].addr));
        chk($sformatf("v%0d_din", i), tram_din, mkdin(tv[i].ch, tv[i].fg, tv[i].bg));
      end
      chk($sformatf("v%0d_cx", i), 32'(cur_x), 32'(tv[i].cx));
      chk($sformatf("v%0d_cy", i), 32'(cur_y), 32'(tv[i].cy));
      chk($sformatf("v%0d_sc", i), 32'(scroll_offs), 32'(tv[i].sc));
      @(negedge clk_sys);
      chk($sformatf("v%0d_we_pulse", i), 32'(tram_we), 32'd0);
    end

    // Bottom-row LF: scroll, clear 12..15, char held during the clear
    colr_fg = 4'd3;
    colr_bg = 4'd2;
    log_clear();
    send(21'h0A);
    chk("scr1_we", 32'(tram_we), 32'd0);
    chk("scr1_sc", 32'(scroll_offs), 32'd4);
    chk("scr1_cx", 32'(cur_x), 32'd0);
    chk("scr1_cy", 32'(cur_y), 32'd2);
    chk("scr1_ready", 32'(ch_ready), 32'd0);
    begin
      int rc;
      int n;
      rc = -1;
      n  = 0;
      ch_valid = 1'b1;
      ch_data  = 21'h51;
      while (n < 100) begin
        @(negedge clk_sys);
        n++;
        if (ch_ready) begin
          rc = cyc;
          @(negedge clk_sys);
          ch_valid = 1'b0;
          break;
        end
      end
      ch_valid = 1'b0;
      chk("scr1_count", 32'(q_addr.size()), 32'd5);
      if (q_addr.size() == 5) begin
        for (int i = 0; i < 4; i++) begin
          chk("scr1_clr_addr", 32'(q_addr[i]), 32'(12 + i));
          chk("scr1_clr_din", q_din[i], mkdin(21'h20, 4'd3, 4'd2));
        end
        chk("scr1_ready_lat", 32'(rc), 32'(q_cyc[3] + 1));
        chk("held_addr", 32'(q_addr[4]), 32'd12);
        chk("held_din", q_din[4], mkdin(21'h51, 4'd3, 4'd2));
        chk("held_lat", 32'(q_cyc[4]), 32'(rc + 1));
      end
      chk("held_cx", 32'(cur_x), 32'd1);
      chk("held_cy", 32'(cur_y), 32'd2);
      chk("held_sc", 32'(scroll_offs), 32'd4);
    end

    // Second bottom LF: scroll to 8, clear wraps to 0..3
    colr_fg = 4'd1;
    colr_bg = 4'd0;
    log_clear();
    send(21'h0A);
    chk("scr2_sc", 32'(scroll_offs), 32'd8);
    chk("scr2_cx", 32'(cur_x), 32'd0);
    chk("scr2_cy", 32'(cur_y), 32'd2);
    expect_clear("scr2_clr", 0, 4);
    send(21'h52);
    chk("wrap_we", 32'(tram_we), 32'd1);
    chk("wrap_addr", 32'(tram_addr_w), 32'd0);
    chk("wrap_cx", 32'(cur_x), 32'd1);

    // Form feed: home, scroll reset, full clear
    log_clear();
    send(21'h0C);
    chk("ff_we", 32'(tram_we), 32'd0);
    chk("ff_sc", 32'(scroll_offs), 32'd0);
    chk("ff_cx", 32'(cur_x), 32'd0);
    chk("ff_cy", 32'(cur_y), 32'd0);
    expect_clear("ff_clr", 0, 12);

    // Reset in the middle of a clear restarts the whole clear
    send(21'h0C);
    repeat (3) @(negedge clk_sys);
    rst_sys_n = 1'b0;
    @(negedge clk_sys);
    chk("mid_rst_we", 32'(tram_we), 32'd0);
    chk("mid_rst_addr", 32'(tram_addr_w), 32'd0);
    chk("mid_rst_din", tram_din, 32'd0);
    chk("mid_rst_ready", 32'(ch_ready), 32'd0);
    log_clear();
    rst_sys_n = 1'b1;
    expect_clear("mid_rst_clr", 0, 12);
    chk("mid_rst_cx", 32'(cur_x), 32'd0);
    chk("mid_rst_cy", 32'(cur_y), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
